// File: rtl/remove_duplicates_sorted_if.sv
// remove_duplicates_sorted_if
//   Handshake bundle for the in-place sorted-array deduplicator.
//   master : load/compute/read controller (drives wr_en, datain, compute_start,
//            rd_en, clear; observes the result side)
//   slave  : the deduplicator itself
//   Ports carried:
//     wr_en, datain        element load into the next buffer slot
//     compute_start        single-cycle pulse starting deduplication
//     rd_en, clear         result readout / return to load phase
//     dataout, rd_valid    registered result element and its strobe
//     uniq_count           number of result elements
//     full, done           buffer full / result ready
interface remove_duplicates_sorted_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] datain;
  logic                  compute_start;
  logic                  rd_en;
  logic                  clear;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  rd_valid;
  logic [CNT_WIDTH-1:0]  uniq_count;
  logic                  full;
  logic                  done;

  modport master (
    output wr_en, datain, compute_start, rd_en, clear,
    input  dataout, rd_valid, uniq_count, full, done
  );

  modport slave (
    input  wr_en, datain, compute_start, rd_en, clear,
    output dataout, rd_valid, uniq_count, full, done
  );
endinterface

// File: rtl/remove_duplicates_sorted.sv
// remove_duplicates_sorted
//   Loads up to DEPTH = 2*NUM_DATA sorted elements, removes duplicates in place
//   with a slow/fast two-pointer scan (one element per cycle), then lets the
//   result be read back one element per rd_en.
//   DATA_WIDTH / NUM_DATA default to the values of config_leetcode.vh
//   (8 and 4); DEPTH matches the merged-array length of the upstream merge.
//   Optional build macro DEDUP_ALLOW_TWICE_EN: keep each value at most twice
//   instead of once. Port list is the same in both builds.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   remove_duplicates_sorted_if.slave (see interface header)
//
//   state     | meaning
//   S_IDLE    | loading elements, waiting for compute_start
//   S_COMPUTE | two-pointer scan, fast walks 1..wr_count-1
//   S_DONE    | result valid (done=1), readout via rd_en, exit via clear
module remove_duplicates_sorted #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DATA   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  remove_duplicates_sorted_if.slave bus
);
  localparam int DEPTH = 2 * NUM_DATA;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] buff [DEPTH];
  logic [CW-1:0]         wr_count;
  logic [CW-1:0]         rd_count;
  logic [CW-1:0]         slow;
  logic [CW-1:0]         fast;
  logic [DATA_WIDTH-1:0] dataout_q;
  logic                  rd_valid_q;
  logic [CW-1:0]         uniq_q;
  logic                  done_q;
  logic                  full_q;

  logic          keep;
  logic          last;
  logic [CW-1:0] slow_next;
  logic [CW-1:0] slow_m1;
  logic [CW-1:0] slow_m2;

  always_comb begin
    keep      = 1'b0;
    slow_m1   = slow - CW'(1);
    slow_m2   = slow - CW'(2);
`ifdef DEDUP_ALLOW_TWICE_EN
    // slow_m2 wraps when slow<2 but is then masked by the first term
    keep      = (slow < CW'(2)) || (buff[fast[AW-1:0]] != buff[slow_m2[AW-1:0]]);
`else
    keep      = (buff[fast[AW-1:0]] != buff[slow_m1[AW-1:0]]);
`endif
    slow_next = keep ? slow + CW'(1) : slow;
    last      = (fast == wr_count - CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_count   <= '0;
      rd_count   <= '0;
      slow       <= '0;
      fast       <= '0;
      dataout_q  <= '0;
      rd_valid_q <= 1'b0;
      uniq_q     <= '0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // compute_start takes precedence; a coincident write is dropped
          if (bus.compute_start) begin
            if (wr_count < CW'(2)) begin
              state  <= S_DONE;
              uniq_q <= wr_count;
              done_q <= 1'b1;
            end else begin
              state <= S_COMPUTE;
              slow  <= CW'(1);
              fast  <= CW'(1);
            end
          end else if (bus.wr_en && (wr_count < CW'(DEPTH))) begin
            buff[wr_count[AW-1:0]] <= bus.datain;
            wr_count               <= wr_count + CW'(1);
            full_q                 <= (wr_count == CW'(DEPTH - 1));
          end
        end
        S_COMPUTE: begin
          if (keep) buff[slow[AW-1:0]] <= buff[fast[AW-1:0]];
          slow <= slow_next;
          fast <= fast + CW'(1);
          if (last) begin
            state  <= S_DONE;
            uniq_q <= slow_next;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.clear) begin
            state    <= S_IDLE;
            wr_count <= '0;
            rd_count <= '0;
            uniq_q   <= '0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
          end else if (bus.rd_en && (rd_count < uniq_q)) begin
            dataout_q  <= buff[rd_count[AW-1:0]];
            rd_count   <= rd_count + CW'(1);
            rd_valid_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dataout    = dataout_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.uniq_count = uniq_q;
  assign bus.done       = done_q;
  assign bus.full       = full_q;
endmodule

// File: tb/tb_remove_duplicates_sorted.sv
module tb_remove_duplicates_sorted;
  localparam int DW = 8;
  localparam int ND = 4;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  remove_duplicates_sorted_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  remove_duplicates_sorted #(.DATA_WIDTH(DW), .NUM_DATA(ND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] v);
    bus.wr_en  = 1'b1;
    bus.datain = v;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  // pulses compute_start and checks the number of edges until done
  task automatic compute(input string tag, input int exp_lat);
    int e;
    bus.compute_start = 1'b1;
    tick();
    bus.compute_start = 1'b0;
    e = 1;
    while (!bus.done && e < 40) begin
      tick();
      e++;
    end
    check({tag, "_latency"}, e, exp_lat);
  endtask

  task automatic rd(input string tag, input logic exp_valid, input logic [DW-1:0] exp_data);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check({tag, "_valid"}, bus.rd_valid, exp_valid);
    check({tag, "_data"}, bus.dataout, exp_data);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  logic [DW-1:0] vec_a [8] = '{1, 1, 2, 3, 3, 3, 5, 8};
`ifdef DEDUP_ALLOW_TWICE_EN
  logic [DW-1:0] res_a [7] = '{1, 1, 2, 3, 3, 5, 8};
  localparam int UA = 7, U7 = 2, UR = 4, U5 = 2;
`else
  logic [DW-1:0] res_a [7] = '{1, 2, 3, 5, 8, 0, 0};
  localparam int UA = 5, U7 = 1, UR = 3, U5 = 1;
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.datain = '0; bus.compute_start = 1'b0;
    bus.rd_en = 1'b0; bus.clear = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_done", bus.done, 0);
    check("rst_full", bus.full, 0);
    check("rst_uniq", bus.uniq_count, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_dataout", bus.dataout, 0);

    // mixed duplicates
    for (int i = 0; i < 8; i++) wr(vec_a[i]);
    check("a_full", bus.full, 1);
    compute("a", 8);
    check("a_uniq", bus.uniq_count, UA);
    for (int i = 0; i < UA; i++) rd($sformatf("a_rd%0d", i), 1'b1, res_a[i]);
    rd("a_rd_past", 1'b0, 8);
    check("a_done_hold", bus.done, 1);
    do_clear();
    check("a_clr_done", bus.done, 0);
    check("a_clr_uniq", bus.uniq_count, 0);
    check("a_clr_full", bus.full, 0);

    // all equal
    for (int i = 0; i < 8; i++) wr(7);
    compute("s", 8);
    check("s_uniq", bus.uniq_count, U7);
    for (int i = 0; i < U7; i++) rd($sformatf("s_rd%0d", i), 1'b1, 7);
    for (int i = U7; i < 8; i++) rd($sformatf("s_rd_past%0d", i), 1'b0, 7);
    do_clear();

    // empty
    compute("e", 1);
    check("e_uniq", bus.uniq_count, 0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("e_rd_valid", bus.rd_valid, 0);
    do_clear();

    // overflow: 9th write dropped
    for (int i = 0; i < 7; i++) wr(DW'(10 + i));
    check("o_full7", bus.full, 0);
    wr(17);
    check("o_full8", bus.full, 1);
    wr(18);
    compute("o", 8);
    check("o_uniq", bus.uniq_count, 8);
    for (int i = 0; i < 8; i++) rd($sformatf("o_rd%0d", i), 1'b1, DW'(10 + i));
    rd("o_rd_past", 1'b0, 17);
    do_clear();

    // reset mid-compute, then reload
    for (int i = 0; i < 8; i++) wr(DW'(20 + i));
    bus.compute_start = 1'b1;
    tick();
    bus.compute_start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_done", bus.done, 0);
    check("r_uniq", bus.uniq_count, 0);
    check("r_full", bus.full, 0);
    wr(2); wr(4); wr(4); wr(6);
    compute("r", 4);
    check("r_uniq2", bus.uniq_count, UR);
    rd("r_rd0", 1'b1, 2);
    rd("r_rd1", 1'b1, 4);
`ifdef DEDUP_ALLOW_TWICE_EN
    rd("r_rd2", 1'b1, 4);
    rd("r_rd3", 1'b1, 6);
`else
    rd("r_rd2", 1'b1, 6);
`endif
    do_clear();

    // two equal elements
    wr(5); wr(5);
    compute("t", 2);
    check("t_uniq", bus.uniq_count, U5);
    for (int i = 0; i < U5; i++) rd($sformatf("t_rd%0d", i), 1'b1, 5);
    rd("t_rd_past", 1'b0, 5);
    do_clear();

    // single element; compute_start beats coincident wr_en
    wr(3);
    bus.wr_en  = 1'b1;
    bus.datain = 9;
    compute("w", 1);
    bus.wr_en  = 1'b0;
    check("w_uniq", bus.uniq_count, 1);
    rd("w_rd0", 1'b1, 3);
    rd("w_rd_past", 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/remove_duplicates_sorted.md
REMOVE_DUPLICATES_SORTED -- requirements
Module: remove_duplicates_sorted

Interface
REQ-001 SHALL take DATA_WIDTH from config_leetcode.vh, value as defined there: element width in bits.
REQ-002 SHALL take NUM_DATA from config_leetcode.vh, value as defined there; buffer DEPTH = 2*NUM_DATA, matching the merged-array length from the upstream merge stage.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  write datain into the next buffer slot.
REQ-006 datain  input  DATA_WIDTH  sorted (non-decreasing) input element.
REQ-007 compute_start  input  1  single-cycle pulse that starts in-place deduplication.
REQ-008 rd_en  input  1  read the next result element.
REQ-009 clear  input  1  return from DONE to IDLE for a new array.
REQ-010 dataout  output  DATA_WIDTH  registered result element.
REQ-011 rd_valid  output  1  dataout updated this cycle.
REQ-012 uniq_count  output  clog2(DEPTH)+1  number of result elements.
REQ-013 full  output  1  wr_count == DEPTH.
REQ-014 done  output  1  result ready; high throughout DONE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE (load), COMPUTE, DONE.
REQ-016 IDLE: wr_en with wr_count<DEPTH writes buff[wr_count] and increments wr_count; wr_en when full, or in any state other than IDLE, is ignored.
REQ-017 IDLE + compute_start, wr_count=0: go to DONE with uniq_count=0.
REQ-018 IDLE + compute_start, wr_count=1: go to DONE with uniq_count=1.
REQ-019 IDLE + compute_start, wr_count>=2: go to COMPUTE with slow=1, fast=1.
REQ-020 compute_start SHALL win over wr_en in the same cycle; that write is dropped.
REQ-021 COMPUTE, each cycle (one element per cycle): if buff[fast] != buff[slow-1], then buff[slow] <= buff[fast] and slow increments; fast always increments.
REQ-022 COMPUTE SHALL exit to DONE after processing fast = wr_count-1, with uniq_count = final slow.
REQ-023 done SHALL rise exactly wr_count clock edges after the edge that samples compute_start (1 edge when wr_count=0).
REQ-024 compute_start outside IDLE SHALL be ignored.
REQ-025 Input ordering is not checked; unsorted input yields the plain two-pointer result with no error flag.
REQ-026 DONE + rd_en with rd_count<uniq_count: dataout <= buff[rd_count], rd_count increments, rd_valid=1 next cycle.
REQ-027 Otherwise rd_valid=0 and dataout holds its value; rd_en past the end of the result is ignored.
REQ-028 DONE + clear: go to IDLE, zero wr_count, rd_count, uniq_count and done; clear in any other state is ignored.
REQ-029 Buffer contents SHALL NOT be cleared by clear or rst.

Reset
REQ-030 rst SHALL force IDLE, zero wr_count, slow, fast and rd_count, and drive dataout=0, rd_valid=0, uniq_count=0, done=0, full=0.
REQ-031 rst SHALL take priority over every other input, including mid-COMPUTE and mid-read.

Configuration
REQ-032 Macro DEDUP_ALLOW_TWICE_EN, when defined, SHALL keep each value at most twice: write when slow<2 or buff[fast] != buff[slow-2].
REQ-033 With DEDUP_ALLOW_TWICE_EN, for wr_count>=2 COMPUTE starts from the same slow=1, fast=1, so latency is identical to REQ-023.
REQ-034 Without DEDUP_ALLOW_TWICE_EN, behaviour SHALL be exactly as REQ-021; the port list is identical in both builds.

Verification (DATA_WIDTH=8, NUM_DATA=4, DEPTH=8)
REQ-035 Load 1,1,2,3,3,3,5,8, then compute_start -> done 8 edges later, uniq_count=5, reads give 1,2,3,5,8; with DEDUP_ALLOW_TWICE_EN: uniq_count=7, reads give 1,1,2,3,3,5,8.
REQ-036 Load eight 7s, then compute -> uniq_count=1, one read of 7 (DEDUP_ALLOW_TWICE_EN: 2, reads 7,7); 9th rd_en gives rd_valid=0.
REQ-037 compute_start with no writes -> done after 1 edge, uniq_count=0, rd_en gives rd_valid=0.
REQ-038 Nine wr_en pulses -> full=1 after the 8th, 9th value dropped, uniq_count reflects 8 elements only.
REQ-039 rst asserted 3 cycles into COMPUTE -> next cycle done=0, uniq_count=0, IDLE; reload 2,4,4,6 and compute -> uniq_count=3, reads 2,4,6.
REQ-040 After reads, clear then load 5,5 and compute -> done 2 edges later, uniq_count=1, read 5.
